// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the two-master memory bus arbiter.
//   arb_state_t    - arbiter FSM state encoding (IDLE / ISSUE / WAIT)
//   REQ_RD/REQ_WR  - latched request kind
//   M_CPU/M_AUX    - master indices (0 = FemtoRV32 CPU, 1 = auxiliary master)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    localparam logic REQ_RD = 1'b0;
    localparam logic REQ_WR = 1'b1;

    localparam logic M_CPU = 1'b0;
    localparam logic M_AUX = 1'b1;

endpackage

// File: rtl/arb_req_slot.sv
// arb_req_slot: per-master request slot for mem_bus_arbiter.
// Captures a strobe-style request (read pulse or nonzero write mask) while
// idle, holds it pending until the arbiter reports completion, and keeps
// the registered read data for the master.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   addr/wdata/wmask/rstrb - master request inputs
//   done            - completion pulse from the arbiter FSM (clears pending,
//                     loads rdata for reads)
//   s_rdata         - slave read data
//   pending, kind, addr_q, wdata_q, wmask_q - latched request to the arbiter
//   rbusy, wbusy    - registered busy outputs to the master
//   rdata           - registered read data to the master
module arb_req_slot
    import mem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic        rstrb,
    input  logic        done,
    input  logic [31:0] s_rdata,
    output logic        pending,
    output logic        kind,
    output logic [31:0] addr_q,
    output logic [31:0] wdata_q,
    output logic [3:0]  wmask_q,
    output logic        rbusy,
    output logic        wbusy,
    output logic [31:0] rdata
);

    logic req;
    logic req_kind;

    // A write takes precedence when strobe and mask arrive together.
    always_comb begin
        req      = rstrb | (|wmask);
        req_kind = (|wmask) ? REQ_WR : REQ_RD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            kind    <= REQ_RD;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rbusy   <= 1'b0;
            wbusy   <= 1'b0;
            rdata   <= '0;
        end else if (!pending) begin
            // New requests are only accepted while nothing is outstanding.
            if (req) begin
                pending <= 1'b1;
                kind    <= req_kind;
                addr_q  <= addr;
                wdata_q <= wdata;
                wmask_q <= wmask;
                rbusy   <= (req_kind == REQ_RD);
                wbusy   <= (req_kind == REQ_WR);
            end
        end else if (done) begin
            pending <= 1'b0;
            rbusy   <= 1'b0;
            wbusy   <= 1'b0;
            if (kind == REQ_RD) begin
                rdata <= s_rdata;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master / one-slave arbiter for the SoC memory bus.
// Master 0 is the CPU, master 1 an auxiliary master (DMA / debug loader).
// Each master's request is held in an arb_req_slot; the FSM grants the
// shared port, issues the access for one cycle and waits RD_LAT cycles for
// read data.
// Parameters:
//   RD_LAT (1..4)  - slave read latency from s_rstrb to valid s_rdata
// Configuration macro:
//   ARB_FIXED_PRIO_EN - when defined, master 0 always wins a contest;
//                       otherwise round-robin on a last-grant pointer.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   m*_addr/wdata/wmask/rstrb         - master requests
//   m*_rdata, m*_rbusy, m*_wbusy      - registered master responses
//   s_addr/s_wdata/s_wmask/s_rstrb    - shared slave port (zero outside ISSUE)
//   s_rdata                           - slave read data
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wmask,
    input  logic        m0_rstrb,
    output logic [31:0] m0_rdata,
    output logic        m0_rbusy,
    output logic        m0_wbusy,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wmask,
    input  logic        m1_rstrb,
    output logic [31:0] m1_rdata,
    output logic        m1_rbusy,
    output logic        m1_wbusy,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wmask,
    output logic        s_rstrb,
    input  logic [31:0] s_rdata
);

    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

    arb_state_t  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        grant_q, grant_d;
    logic        pick;
    logic        done_any, done0, done1;

    logic        pend0, pend1;
    logic        kind0, kind1;
    logic [31:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [3:0]  wmask0, wmask1;

    logic        g_kind;
    logic [31:0] g_addr, g_wdata;
    logic [3:0]  g_wmask;

    arb_req_slot u_slot0 (
        .clk     (clk),
        .rst     (rst),
        .addr    (m0_addr),
        .wdata   (m0_wdata),
        .wmask   (m0_wmask),
        .rstrb   (m0_rstrb),
        .done    (done0),
        .s_rdata (s_rdata),
        .pending (pend0),
        .kind    (kind0),
        .addr_q  (addr0),
        .wdata_q (wdata0),
        .wmask_q (wmask0),
        .rbusy   (m0_rbusy),
        .wbusy   (m0_wbusy),
        .rdata   (m0_rdata)
    );

    arb_req_slot u_slot1 (
        .clk     (clk),
        .rst     (rst),
        .addr    (m1_addr),
        .wdata   (m1_wdata),
        .wmask   (m1_wmask),
        .rstrb   (m1_rstrb),
        .done    (done1),
        .s_rdata (s_rdata),
        .pending (pend1),
        .kind    (kind1),
        .addr_q  (addr1),
        .wdata_q (wdata1),
        .wmask_q (wmask1),
        .rbusy   (m1_rbusy),
        .wbusy   (m1_wbusy),
        .rdata   (m1_rdata)
    );

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        pick = pend0 ? M_CPU : M_AUX;
    end
`else
    logic last_q;

    // Contest goes to the master not granted last; otherwise to whoever
    // is pending.
    always_comb begin
        if (pend0 && pend1) begin
            pick = ~last_q;
        end else if (pend0) begin
            pick = M_CPU;
        end else begin
            pick = M_AUX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= M_AUX;
        end else if (state_q == ST_IDLE && (pend0 || pend1)) begin
            last_q <= pick;
        end
    end
`endif

    // Granted slot, selected only by the grant register.
    always_comb begin
        g_kind  = (grant_q == M_AUX) ? kind1  : kind0;
        g_addr  = (grant_q == M_AUX) ? addr1  : addr0;
        g_wdata = (grant_q == M_AUX) ? wdata1 : wdata0;
        g_wmask = (grant_q == M_AUX) ? wmask1 : wmask0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            grant_q <= M_CPU;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        done_any = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend0 || pend1) begin
                    grant_d = pick;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (g_kind == REQ_WR) begin
                    done_any = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d   = LAT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 2'd0) begin
                    done_any = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        done0 = done_any && (grant_q == M_CPU);
        done1 = done_any && (grant_q == M_AUX);
    end

    always_comb begin
        s_addr  = '0;
        s_wdata = '0;
        s_wmask = '0;
        s_rstrb = 1'b0;
        if (state_q == ST_ISSUE) begin
            s_addr  = g_addr;
            s_wdata = g_wdata;
            s_wmask = g_wmask;
            s_rstrb = (g_kind == REQ_RD);
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed, scoreboard-checked bench for mem_bus_arbiter.
// Instance d1 uses RD_LAT=1 with two active masters; instance d3 uses
// RD_LAT=3 with master 0 only, for latency and mid-read reset cases.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    // d1 (RD_LAT = 1)
    logic        rst;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wmask, m1_wmask;
    logic        m0_rstrb, m1_rstrb;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wmask;
    logic        s_rstrb;

    // d3 (RD_LAT = 3)
    logic        rst3;
    logic [31:0] c_m0_addr;
    logic        c_m0_rstrb;
    logic [31:0] c_m0_rdata, c_m1_rdata;
    logic        c_m0_rbusy, c_m0_wbusy, c_m1_rbusy, c_m1_wbusy;
    logic [31:0] c_s_addr, c_s_wdata, c_s_rdata;
    logic [3:0]  c_s_wmask;
    logic        c_s_rstrb;

    mem_bus_arbiter #(.RD_LAT(1)) d1 (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
        .m0_rdata(m0_rdata), .m0_rbusy(m0_rbusy), .m0_wbusy(m0_wbusy),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
        .m1_rdata(m1_rdata), .m1_rbusy(m1_rbusy), .m1_wbusy(m1_wbusy),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask), .s_rstrb(s_rstrb),
        .s_rdata(s_rdata)
    );

    mem_bus_arbiter #(.RD_LAT(3)) d3 (
        .clk(clk), .rst(rst3),
        .m0_addr(c_m0_addr), .m0_wdata(32'h0), .m0_wmask(4'h0), .m0_rstrb(c_m0_rstrb),
        .m0_rdata(c_m0_rdata), .m0_rbusy(c_m0_rbusy), .m0_wbusy(c_m0_wbusy),
        .m1_addr(32'h0), .m1_wdata(32'h0), .m1_wmask(4'h0), .m1_rstrb(1'b0),
        .m1_rdata(c_m1_rdata), .m1_rbusy(c_m1_rbusy), .m1_wbusy(c_m1_wbusy),
        .s_addr(c_s_addr), .s_wdata(c_s_wdata), .s_wmask(c_s_wmask), .s_rstrb(c_s_rstrb),
        .s_rdata(c_s_rdata)
    );

    // ---------------- slave RAM model ----------------
    function automatic logic [31:0] init_word(input logic [7:0] idx);
        return (idx == 8'd4) ? 32'hDEADBEEF : (32'hC0DE0000 | {24'h0, idx});
    endfunction

    logic [31:0] ram [0:255];
    logic [255:0] wr_flag;
    logic        v1;
    logic [31:0] d1q;
    logic [2:0]  v3;
    logic [31:0] d3q [0:2];

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return wr_flag[a[9:2]] ? ram[a[9:2]] : init_word(a[9:2]);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            wr_flag <= '0;
            v1      <= 1'b0;
            v3      <= '0;
        end else begin
            if (s_wmask != 4'h0) begin
                for (int b = 0; b < 4; b++) begin
                    ram[s_addr[9:2]][8*b +: 8] <= s_wmask[b] ? s_wdata[8*b +: 8]
                                                             : ram_rd(s_addr)[8*b +: 8];
                end
                wr_flag[s_addr[9:2]] <= 1'b1;
            end
            v1     <= s_rstrb;
            d1q    <= ram_rd(s_addr);
            v3     <= {v3[1:0], c_s_rstrb};
            d3q[0] <= ram_rd(c_s_addr);
            d3q[1] <= d3q[0];
            d3q[2] <= d3q[1];
        end
    end

    assign s_rdata   = v1    ? d1q    : 32'hBAD0BAD0;
    assign c_s_rdata = v3[2] ? d3q[2] : 32'hBAD0BAD0;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } iss_t;

    iss_t        iss_q [$];
    logic [31:0] rd0_q [$];
    logic [31:0] rd1_q [$];
    logic [31:0] exp_mem [0:255];
    int          n_cmp  = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    iss_t        e;
    logic        pb0, pb1;
    logic [31:0] x;

    always @(negedge clk) begin
        if (rst) begin
            pb0 = 1'b0;
            pb1 = 1'b0;
        end else begin
            if (s_rstrb || s_wmask != 4'h0) begin
                n_cmp++;
                assert (iss_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_issue: observed s_addr %08h rstrb %0b, expected no access", s_addr, s_rstrb);
                end
                if (iss_q.size() != 0) begin
                    e = iss_q.pop_front();
                    check("sb_s_addr",  s_addr,  e.addr);
                    check("sb_s_rstrb", {31'h0, s_rstrb}, {31'h0, e.rd});
                    check("sb_s_wmask", {28'h0, s_wmask}, {28'h0, e.wmask});
                    check("sb_s_wdata", s_wdata, e.wdata);
                end
            end else begin
                check("s_addr_idle",  s_addr,  32'h0);
                check("s_wdata_idle", s_wdata, 32'h0);
            end
            if (pb0 && !m0_rbusy) begin
                n_cmp++;
                assert (rd0_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL m0_unexpected_read: observed rdata %08h, expected no completion", m0_rdata);
                end
                if (rd0_q.size() != 0) begin
                    x = rd0_q.pop_front();
                    check("sb_m0_rdata", m0_rdata, x);
                end
            end
            if (pb1 && !m1_rbusy) begin
                n_cmp++;
                assert (rd1_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL m1_unexpected_read: observed rdata %08h, expected no completion", m1_rdata);
                end
                if (rd1_q.size() != 0) begin
                    x = rd1_q.pop_front();
                    check("sb_m1_rdata", m1_rdata, x);
                end
            end
            pb0 = m0_rbusy;
            pb1 = m1_rbusy;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_rd(input int m, input logic [31:0] a);
        iss_q.push_back('{rd: 1'b1, addr: a, wdata: 32'h0, wmask: 4'h0});
        if (m == 0) rd0_q.push_back(exp_mem[a[9:2]]);
        else        rd1_q.push_back(exp_mem[a[9:2]]);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end of the sequence");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    int          first_m;
    int          nstr;
    logic [31:0] a_first, a_second;

    initial begin
        rst = 1'b1; rst3 = 1'b1;
        m0_addr = '0; m0_wdata = '0; m0_wmask = '0; m0_rstrb = 1'b0;
        m1_addr = '0; m1_wdata = '0; m1_wmask = '0; m1_rstrb = 1'b0;
        c_m0_addr = '0; c_m0_rstrb = 1'b0;
        for (int i = 0; i < 256; i++) exp_mem[i] = init_word(8'(i));

        // 1. Reset: two cycles, all outputs zero.
        step(); step();
        check("rst_m0_rdata", m0_rdata, 32'h0);
        check("rst_m1_rdata", m1_rdata, 32'h0);
        check("rst_busy", {28'h0, m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy}, 32'h0);
        check("rst_s_addr", s_addr, 32'h0);
        check("rst_s_ctl", {27'h0, s_rstrb, s_wmask}, 32'h0);
        check("rst_s_wdata", s_wdata, 32'h0);
        check("rst_d3_out", c_m0_rdata | c_m1_rdata | c_s_addr | c_s_wdata, 32'h0);
        check("rst_d3_ctl", {26'h0, c_m0_rbusy, c_m0_wbusy, c_m1_rbusy, c_m1_wbusy, c_s_rstrb, |c_s_wmask}, 32'h0);
        rst = 1'b0; rst3 = 1'b0;

        // 4a. Contention round 1: pointer out of reset favours m0.
        m0_rstrb = 1'b1; m0_addr = 32'h30;
        m1_rstrb = 1'b1; m1_addr = 32'h34;
        push_rd(0, 32'h30); push_rd(1, 32'h34);
        step();                                            // T1
        m0_rstrb = 1'b0; m1_rstrb = 1'b0;
        check("c1_T1_busy", {30'h0, m0_rbusy, m1_rbusy}, 32'h3);
        step();                                            // T2
        check("c1_T2_strobe", {31'h0, s_rstrb}, 32'h1);
        check("c1_T2_addr", s_addr, 32'h30);
        step(); step();                                    // T4
        check("c1_T4_busy", {30'h0, m0_rbusy, m1_rbusy}, 32'h1);
        check("c1_T4_m0_rdata", m0_rdata, 32'hC0DE000C);
        step();                                            // T5
        check("c1_T5_strobe", {31'h0, s_rstrb}, 32'h1);
        check("c1_T5_addr", s_addr, 32'h34);
        step(); step();                                    // T7
        check("c1_T7_busy", {30'h0, m0_rbusy, m1_rbusy}, 32'h0);
        check("c1_T7_m1_rdata", m1_rdata, 32'hC0DE000D);

        // 2. Single uncontended read of 0x10.
        m0_rstrb = 1'b1; m0_addr = 32'h10;
        push_rd(0, 32'h10);
        step();                                            // T1
        m0_rstrb = 1'b0;
        check("rd_T1_rbusy", {31'h0, m0_rbusy}, 32'h1);
        check("rd_T1_strobe", {31'h0, s_rstrb}, 32'h0);
        step();                                            // T2
        check("rd_T2_strobe", {31'h0, s_rstrb}, 32'h1);
        check("rd_T2_rbusy", {31'h0, m0_rbusy}, 32'h1);
        step();                                            // T3
        check("rd_T3_strobe", {31'h0, s_rstrb}, 32'h0);
        check("rd_T3_rbusy", {31'h0, m0_rbusy}, 32'h1);
        step();                                            // T4
        check("rd_T4_rbusy", {31'h0, m0_rbusy}, 32'h0);
        check("rd_T4_rdata", m0_rdata, 32'hDEADBEEF);

        // 4b. Contention round 2: last grant was m0, so round-robin picks m1.
        first_m  = FIXED ? 0 : 1;
        a_first  = FIXED ? 32'h38 : 32'h3C;
        a_second = FIXED ? 32'h3C : 32'h38;
        m0_rstrb = 1'b1; m0_addr = 32'h38;
        m1_rstrb = 1'b1; m1_addr = 32'h3C;
        if (FIXED) begin
            push_rd(0, 32'h38); push_rd(1, 32'h3C);
        end else begin
            push_rd(1, 32'h3C); push_rd(0, 32'h38);
        end
        step();                                            // T1
        m0_rstrb = 1'b0; m1_rstrb = 1'b0;
        step();                                            // T2
        check("c2_T2_addr", s_addr, a_first);
        step(); step();                                    // T4
        check("c2_T4_busy", {30'h0, m0_rbusy, m1_rbusy}, (first_m == 0) ? 32'h1 : 32'h2);
        step();                                            // T5
        check("c2_T5_addr", s_addr, a_second);
        step(); step();                                    // T7
        check("c2_T7_busy", {30'h0, m0_rbusy, m1_rbusy}, 32'h0);

        // 3. m1 write (strobe also set: write wins), then m0 read-back.
        m1_wmask = 4'hF; m1_wdata = 32'h12345678; m1_addr = 32'h20; m1_rstrb = 1'b1;
        iss_q.push_back('{rd: 1'b0, addr: 32'h20, wdata: 32'h12345678, wmask: 4'hF});
        exp_mem[8] = 32'h12345678;
        step();                                            // T1
        m1_wmask = 4'h0; m1_rstrb = 1'b0; m1_wdata = 32'h0;
        check("wr_T1_busy", {30'h0, m1_rbusy, m1_wbusy}, 32'h1);
        step();                                            // T2
        check("wr_T2_wmask", {28'h0, s_wmask}, 32'hF);
        check("wr_T2_strobe", {31'h0, s_rstrb}, 32'h0);
        step();                                            // T3
        check("wr_T3_wbusy", {31'h0, m1_wbusy}, 32'h0);
        m0_rstrb = 1'b1; m0_addr = 32'h20;
        push_rd(0, 32'h20);
        step();
        m0_rstrb = 1'b0;
        step(); step(); step();
        check("wr_readback", m0_rdata, 32'h12345678);
        check("wr_readback_rbusy", {31'h0, m0_rbusy}, 32'h0);

        // 6a. Duplicate m0 strobe while pending is ignored.
        m0_rstrb = 1'b1; m0_addr = 32'h10;
        push_rd(0, 32'h10);
        nstr = 0;
        step();                                            // T1
        m0_addr = 32'h30;                                  // duplicate request
        step();                                            // T2
        m0_rstrb = 1'b0;
        nstr += int'(s_rstrb);
        for (int k = 0; k < 4; k++) begin
            step();
            nstr += int'(s_rstrb);
        end
        check("dup_strobe_count", 32'(nstr), 32'h1);
        check("dup_rdata", m0_rdata, 32'hDEADBEEF);

        // 6b. RD_LAT=3: busy for 5 cycles.
        c_m0_rstrb = 1'b1; c_m0_addr = 32'h10;
        step();                                            // T1
        c_m0_rstrb = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("lat3_T%0d_rbusy", k), {31'h0, c_m0_rbusy}, 32'h1);
            check($sformatf("lat3_T%0d_strobe", k), {31'h0, c_s_rstrb}, (k == 2) ? 32'h1 : 32'h0);
            step();
        end
        check("lat3_T6_rbusy", {31'h0, c_m0_rbusy}, 32'h0);
        check("lat3_T6_rdata", c_m0_rdata, 32'hDEADBEEF);

        // 5. Reset during WAIT drops the read and clears rdata.
        c_m0_rstrb = 1'b1; c_m0_addr = 32'h30;
        step();                                            // T1
        c_m0_rstrb = 1'b0;
        step(); step();                                    // T3, in WAIT
        check("mid_T3_rbusy", {31'h0, c_m0_rbusy}, 32'h1);
        rst3 = 1'b1;
        step();                                            // T4
        rst3 = 1'b0;
        for (int k = 4; k <= 6; k++) begin
            check($sformatf("mid_T%0d_rbusy", k), {31'h0, c_m0_rbusy}, 32'h0);
            check($sformatf("mid_T%0d_rdata", k), c_m0_rdata, 32'h0);
            check($sformatf("mid_T%0d_strobe", k), {31'h0, c_s_rstrb}, 32'h0);
            step();
        end
        c_m0_rstrb = 1'b1; c_m0_addr = 32'h20;
        step();
        c_m0_rstrb = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("mid_after_rdata", c_m0_rdata, 32'h12345678);
        check("mid_after_rbusy", {31'h0, c_m0_rbusy}, 32'h0);

        step();
        check("iss_q_drained", 32'(iss_q.size()), 32'h0);
        check("rd0_q_drained", 32'(rd0_q.size()), 32'h0);
        check("rd1_q_drained", 32'(rd1_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
